// File: rtl/push_button_debouncer.sv
// Push-button conditioner: synchronises the raw pin, debounces it with a four-state FSM and
// produces a clean level plus registered rise, fall and long-press pulses.
module push_button_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 1000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_raw,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic btn_hold,
    output logic btn_busy
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] DEB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_MAX = CNT_WIDTH'(HOLD_CYCLES);
    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_b;
    state_t                 state;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   hold_cnt;
    logic                   hold_inc;
    logic                   hold_last;

    assign sync_b = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], button_raw};
    end

    // Hold counter saturates at HOLD_MAX, so the pulse fires only on the reaching edge.
    assign hold_inc  = (HOLD_CYCLES != 0) && (hold_cnt != HOLD_MAX);
    assign hold_last = hold_inc && (hold_cnt == HOLD_MAX - ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE_LOW;
            cnt       <= '0;
            hold_cnt  <= '0;
            btn_level <= 1'b0;
            btn_rise  <= 1'b0;
            btn_fall  <= 1'b0;
            btn_hold  <= 1'b0;
            btn_busy  <= 1'b0;
        end else begin
            btn_rise <= 1'b0;
            btn_fall <= 1'b0;
            btn_hold <= 1'b0;
            case (state)
                IDLE_LOW: begin
                    hold_cnt <= '0;
                    if (sync_b) begin
                        state    <= WAIT_HIGH;
                        cnt      <= ONE;
                        btn_busy <= 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (!sync_b) begin
                        state    <= IDLE_LOW;
                        cnt      <= '0;
                        btn_busy <= 1'b0;
                    end else if (cnt == DEB_LAST) begin
                        state     <= IDLE_HIGH;
                        cnt       <= '0;
                        hold_cnt  <= '0;
                        btn_level <= 1'b1;
                        btn_rise  <= 1'b1;
                        btn_busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (hold_inc) hold_cnt <= hold_cnt + ONE;
                    btn_hold <= hold_last;
                    if (!sync_b) begin
                        state    <= WAIT_LOW;
                        cnt      <= ONE;
                        btn_busy <= 1'b1;
                    end
                end
                WAIT_LOW: begin
                    if (sync_b) begin
                        // Glitch while high: the press is still in progress, keep hold_cnt.
                        state    <= IDLE_HIGH;
                        cnt      <= '0;
                        btn_busy <= 1'b0;
                        if (hold_inc) hold_cnt <= hold_cnt + ONE;
                        btn_hold <= hold_last;
                    end else if (cnt == DEB_LAST) begin
                        state     <= IDLE_LOW;
                        cnt       <= '0;
                        hold_cnt  <= '0;
                        btn_level <= 1'b0;
                        btn_fall  <= 1'b1;
                        btn_busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + ONE;
                        if (hold_inc) hold_cnt <= hold_cnt + ONE;
                        btn_hold <= hold_last;
                    end
                end
                default: begin
                    state    <= IDLE_LOW;
                    cnt      <= '0;
                    hold_cnt <= '0;
                    btn_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
